// File: rtl/rf_dump.sv
// Sequential register-file reader: walks [first..last] (wrapping) and streams bytes over valid/ready.
// Optional trailing XOR checksum byte when RF_DUMP_CHECKSUM_EN is defined.
module rf_dump #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] first,
    input  logic [AW-1:0] last,
    output logic [AW-1:0] rd_ptr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND,
`ifdef RF_DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_cur;
    logic [AW-1:0] r_end;
    logic [DW-1:0] r_out_data;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_busy;
    logic          r_done;
`ifdef RF_DUMP_CHECKSUM_EN
    logic [DW-1:0] r_csum;
`endif

    logic w_at_end;
    logic w_fire;

    assign w_at_end  = (r_cur == r_end);
    assign w_fire    = r_out_valid && out_ready;
    assign rd_ptr    = r_cur;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_end       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur   <= first;
                        r_end   <= last;
                        r_busy  <= 1'b1;
                        r_state <= S_READ;
`ifdef RF_DUMP_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                S_READ: begin
                    r_out_data  <= rd_data;
                    r_out_valid <= 1'b1;
`ifdef RF_DUMP_CHECKSUM_EN
                    r_csum      <= r_csum ^ rd_data;
                    r_out_last  <= 1'b0;
`else
                    r_out_last  <= w_at_end;
`endif
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (w_fire) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (w_at_end) begin
`ifdef RF_DUMP_CHECKSUM_EN
                            // Checksum already includes the final byte, so it can be presented now.
                            r_out_data  <= r_csum;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b1;
                            r_state     <= S_CSUM;
`else
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
`endif
                        end else begin
                            r_cur   <= r_cur + 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end
`ifdef RF_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (w_fire) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_dump.sv
// Scoreboard bench for rf_dump: stimulus pushes expected {last,data}, a negedge monitor pops on handshake.
module tb_rf_dump;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] first, last;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [16];
    assign rd_data = rf[rd_ptr];

    rf_dump #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first(first), .last(last),
        .rd_ptr(rd_ptr), .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int pop_cnt = 0;
    bit toggle_ready = 1'b0;
    logic [DW:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 out_ready = toggle_ready ? ~out_ready : 1'b1;
        end
    end

    // Monitor: negedge sees the values that the next posedge will act on.
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {23'd0, out_last, out_data}, {23'd0, prev_last, prev_data});
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", out_data);
                end else begin
                    chk("stream", {23'd0, out_last, out_data}, {23'd0, sb.pop_front()});
                end
                pop_cnt++;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
        end
    end

    task automatic push_range(input logic [AW-1:0] f, input logic [AW-1:0] l);
        logic [AW-1:0] a;
        logic [DW-1:0] x;
        a = f;
        x = '0;
        forever begin
            x = x ^ rf[a];
`ifdef RF_DUMP_CHECKSUM_EN
            sb.push_back({1'b0, rf[a]});
`else
            sb.push_back({(a == l), rf[a]});
`endif
            if (a == l) break;
            a = a + 1'b1;
        end
`ifdef RF_DUMP_CHECKSUM_EN
        sb.push_back({1'b1, x});
`endif
    endtask

    task automatic kick(input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(posedge clk);
        #1;
        first = f; last = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(done_cnt > 0 && !busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, {31'd0, (n >= 400)}, 32'd0);
        repeat (3) @(negedge clk);
        chk({name, "_done_once"}, done_cnt, 1);
        chk({name, "_sb_empty"}, sb.size(), 0);
        chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run(input string name, input logic [AW-1:0] f, input logic [AW-1:0] l);
        done_cnt = 0;
        push_range(f, l);
        kick(f, l);
        wait_done(name);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; first = '0; last = '0;
        for (int i = 0; i < 16; i++) rf[i] = 8'hC0 + 8'(i);
        repeat (2) @(negedge clk);
        chk("rst_outputs", {17'd0, rd_ptr, out_data, out_valid, out_last, busy, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        rf[0] = 8'h11; rf[1] = 8'h22; rf[2] = 8'h33; rf[3] = 8'h44;
        run("basic", 4'd0, 4'd3);

        toggle_ready = 1'b1;
        run("toggle", 4'd0, 4'd3);
        toggle_ready = 1'b0;

        rf[14] = 8'hAE; rf[15] = 8'hAF; rf[0] = 8'hA0; rf[1] = 8'hA1;
        run("wrap", 4'd14, 4'd1);

        rf[5] = 8'h5A;
        run("single", 4'd5, 4'd5);

        for (int i = 0; i < 16; i++) rf[i] = 8'h30 + 8'(i);
        run("full16", 4'd3, 4'd2);

        // A second start while busy must not disturb the running dump.
        done_cnt = 0;
        push_range(4'd0, 4'd3);
        kick(4'd0, 4'd3);
        repeat (2) @(posedge clk);
        #1 first = 4'd8; last = 4'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("ignore_start");

        // Reset mid-dump after two bytes have been accepted.
        done_cnt = 0;
        pop_cnt = 0;
        push_range(4'd0, 4'd3);
        kick(4'd0, 4'd3);
        n = 0;
        while (pop_cnt < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rst_reach", {31'd0, (pop_cnt >= 2)}, 32'd1);
        chk("mid_rst_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_drop", {29'd0, out_valid, busy, done}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rf[0] = 8'h01; rf[1] = 8'h02;
        run("after_rst", 4'd0, 4'd1);

        rf[0] = 8'h01; rf[1] = 8'h02; rf[2] = 8'h04;
        run("csum", 4'd0, 4'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
